// File: rtl/stage_sequencer_pkg.sv
// Shared state encodings for the order-stage sequencer and its neighbours.
package stage_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_STOPPED = 3'd0,
    ST_PRIME   = 3'd1,
    ST_ARMED   = 3'd2,
    ST_STAGE1  = 3'd3,
    ST_STAGE2  = 3'd4
  } state_t;

  function automatic logic is_running(input state_t s);
    return (s == ST_STAGE1) || (s == ST_STAGE2);
  endfunction

endpackage

// File: rtl/stage_sequencer_start_timer.sv
// Loadable down-counter timing the PRIME phase; zero flag decoded from the count register.
module start_timer #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Decrement saturates at zero so a late dec cannot wrap the count.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/stage_sequencer.sv
// Order-stage sequencer: start/prime/arm, then alternates stage 1 and stage 2 on epsep.
// Optional completed-order counter enabled by macro STAGE_ORDER_COUNT_EN.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int START_DELAY = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stop_neg_i,
  input  logic             epsep_i,
  input  logic             stop_order_i,
  output logic             s1_o,
  output logic             s2_o,
  output logic             starter_neg_o,
  output logic             sep2_o,
`ifdef STAGE_ORDER_COUNT_EN
  output logic             running_o,
  output logic [CNT_W-1:0] order_count_o
`else
  output logic             running_o
`endif
);

  localparam int TMR_W = $clog2(START_DELAY + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(START_DELAY - 1);

  state_t state_q;
  state_t state_d;
  logic   sep2_q;
  logic   sep2_d;
  logic   tmr_load;
  logic   tmr_dec;
  logic   tmr_zero;

  start_timer #(
    .W(TMR_W)
  ) u_start_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .load_val_i (TMR_LOAD),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_STOPPED;
      sep2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sep2_q  <= sep2_d;
    end
  end

  // A stop request always beats progress, so PRIME aborts without kicking sep2.
  always_comb begin
    state_d  = state_q;
    sep2_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    unique case (state_q)
      ST_STOPPED: begin
        if (start_i) begin
          state_d  = ST_PRIME;
          tmr_load = 1'b1;
        end
      end
      ST_PRIME: begin
        if (!stop_neg_i) begin
          state_d = ST_STOPPED;
        end else if (tmr_zero) begin
          state_d = ST_ARMED;
          sep2_d  = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_ARMED: begin
        if (!stop_neg_i) begin
          state_d = ST_STOPPED;
        end else if (epsep_i) begin
          state_d = ST_STAGE1;
        end
      end
      ST_STAGE1: begin
        if (epsep_i) begin
          state_d = stop_neg_i ? ST_STAGE2 : ST_STOPPED;
        end
      end
      ST_STAGE2: begin
        if (epsep_i) begin
          state_d = (stop_order_i || !stop_neg_i) ? ST_STOPPED : ST_STAGE1;
        end
      end
      default: state_d = ST_STOPPED;
    endcase
  end

  always_comb begin
    s1_o          = (state_q == ST_STAGE1);
    s2_o          = (state_q == ST_STAGE2);
    starter_neg_o = (state_q != ST_STOPPED);
    running_o     = is_running(state_q);
    sep2_o        = sep2_q;
  end

`ifdef STAGE_ORDER_COUNT_EN
  logic [CNT_W-1:0] order_cnt_q;
  logic [CNT_W-1:0] order_cnt_d;

  // Every stage-2 end completes an order, including one that stops the machine.
  always_comb begin
    order_cnt_d = order_cnt_q;
    if ((state_q == ST_STAGE2) && epsep_i) begin
      order_cnt_d = order_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      order_cnt_q <= '0;
    end else begin
      order_cnt_q <= order_cnt_d;
    end
  end

  assign order_count_o = order_cnt_q;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench: each driven cycle queues the outputs expected after its clock edge.
module tb_stage_sequencer;

  localparam int START_DELAY = 4;
  localparam int CNT_W       = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic stop_neg = 1'b1;
  logic epsep = 1'b0;
  logic stop_order = 1'b0;
  logic s1, s2, starter_neg, sep2, running;
  logic [CNT_W-1:0] order_count;

  typedef struct {
    string       tag;
    logic  [4:0] outs;
    int          cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  stage_sequencer #(
    .START_DELAY(START_DELAY),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .stop_neg_i   (stop_neg),
    .epsep_i      (epsep),
    .stop_order_i (stop_order),
    .s1_o         (s1),
    .s2_o         (s2),
    .starter_neg_o(starter_neg),
    .sep2_o       (sep2),
`ifdef STAGE_ORDER_COUNT_EN
    .running_o    (running),
    .order_count_o(order_count)
`else
    .running_o    (running)
`endif
  );

`ifndef STAGE_ORDER_COUNT_EN
  assign order_count = '0;
`endif

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Expected vector bits: {s1, s2, starter_neg, sep2, running}.
  task automatic cyc(input string tag, input bit r, input bit st, input bit sn,
                     input bit ep, input bit so, input logic [4:0] outs, input int cnt);
    exp_t e;
    rst        = r;
    start      = st;
    stop_neg   = sn;
    epsep      = ep;
    stop_order = so;
    e.tag  = tag;
    e.outs = outs;
    e.cnt  = cnt;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.tag, ".s1"},          int'(s1),          int'(e.outs[4]));
      chk({e.tag, ".s2"},          int'(s2),          int'(e.outs[3]));
      chk({e.tag, ".starter_neg"}, int'(starter_neg), int'(e.outs[2]));
      chk({e.tag, ".sep2"},        int'(sep2),        int'(e.outs[1]));
      chk({e.tag, ".running"},     int'(running),     int'(e.outs[0]));
`ifdef STAGE_ORDER_COUNT_EN
      chk({e.tag, ".order_count"}, int'(order_count), e.cnt);
`endif
    end
  end

  // start, three countdown clocks, sep2 kick, then sep2 echoed back as epsep.
  task automatic to_stage1(input string tag, input int cnt);
    cyc({tag, "_start"}, 0, 1, 1, 0, 0, 5'b00100, cnt);
    for (int i = 0; i < START_DELAY - 1; i++)
      cyc({tag, "_prime"}, 0, 0, 1, 0, 0, 5'b00100, cnt);
    cyc({tag, "_sep2"},  0, 0, 1, 0, 0, 5'b00110, cnt);
    cyc({tag, "_echo"},  0, 0, 1, 1, 0, 5'b10101, cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d, expected 0",
             exp_q.size());
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    cyc("reset0", 1, 0, 1, 0, 0, 5'b00000, 0);
    cyc("reset1", 1, 1, 1, 1, 0, 5'b00000, 0);
    cyc("idle_ep", 0, 0, 1, 1, 0, 5'b00000, 0);

    // Start sequence with epsep one clock after the sep2 kick.
    cyc("A_c0", 0, 1, 1, 0, 0, 5'b00100, 0);
    cyc("A_c1", 0, 0, 1, 0, 0, 5'b00100, 0);
    cyc("A_c2", 0, 0, 1, 0, 0, 5'b00100, 0);
    cyc("A_c3", 0, 0, 1, 0, 0, 5'b00100, 0);
    cyc("A_c4", 0, 0, 1, 0, 0, 5'b00110, 0);
    cyc("A_c5", 0, 0, 1, 0, 0, 5'b00100, 0);
    cyc("A_c6", 0, 0, 1, 1, 0, 5'b10101, 0);
    cyc("A_hold1", 0, 0, 1, 0, 0, 5'b10101, 0);
    cyc("A_ep1",   0, 0, 1, 1, 0, 5'b01101, 0);
    cyc("A_hold2", 0, 0, 1, 0, 0, 5'b01101, 0);
    cyc("A_ep2",   0, 0, 1, 1, 0, 5'b10101, 1);
    cyc("A_ep3",   0, 0, 1, 1, 0, 5'b01101, 1);
    cyc("A_stopz", 0, 0, 1, 1, 1, 5'b00000, 2);

    // Stop during PRIME: back to STOPPED, sep2 never fires.
    cyc("B_c0", 0, 1, 1, 0, 0, 5'b00100, 2);
    cyc("B_c1", 0, 0, 1, 0, 0, 5'b00100, 2);
    cyc("B_c2", 0, 0, 0, 0, 0, 5'b00000, 2);
    for (int i = 0; i < 5; i++)
      cyc("B_quiet", 0, 0, 1, 0, 0, 5'b00000, 2);

    // start+epsep together in STOPPED, start ignored in STAGE1, counter wrap.
    cyc("C_both", 0, 1, 1, 1, 0, 5'b00100, 2);
    for (int i = 0; i < START_DELAY - 1; i++)
      cyc("C_prime", 0, 0, 1, 0, 0, 5'b00100, 2);
    cyc("C_sep2",  0, 0, 1, 0, 0, 5'b00110, 2);
    cyc("C_echo",  0, 0, 1, 1, 0, 5'b10101, 2);
    cyc("C_start_s1", 0, 1, 1, 0, 0, 5'b10101, 2);
    cyc("C_ep1",   0, 0, 1, 1, 0, 5'b01101, 2);
    cyc("C_start_s2", 0, 1, 1, 0, 0, 5'b01101, 2);
    cyc("C_ep2",   0, 0, 1, 1, 0, 5'b10101, 3);
    cyc("C_ep3",   0, 0, 1, 1, 0, 5'b01101, 3);
    cyc("C_wrap",  0, 0, 1, 1, 0, 5'b10101, 0);
    cyc("C_s1stop", 0, 0, 0, 1, 0, 5'b00000, 0);

    // Stop while ARMED.
    cyc("D_c0", 0, 1, 1, 0, 0, 5'b00100, 0);
    for (int i = 0; i < START_DELAY - 1; i++)
      cyc("D_prime", 0, 0, 1, 0, 0, 5'b00100, 0);
    cyc("D_sep2",  0, 0, 1, 0, 0, 5'b00110, 0);
    cyc("D_armed", 0, 0, 1, 0, 0, 5'b00100, 0);
    cyc("D_stop",  0, 0, 0, 1, 0, 5'b00000, 0);

    // stop_neg low with epsep in STAGE2 still completes the order.
    to_stage1("E", 0);
    cyc("E_ep1",   0, 0, 1, 1, 0, 5'b01101, 0);
    cyc("E_stopn", 0, 0, 0, 1, 0, 5'b00000, 1);

    // Reset mid-stage clears state and counter.
    to_stage1("F", 1);
    cyc("F_ep1", 0, 0, 1, 1, 0, 5'b01101, 1);
    cyc("F_ep2", 0, 0, 1, 1, 0, 5'b10101, 2);
    cyc("F_rst", 1, 0, 1, 1, 0, 5'b00000, 0);
    cyc("F_after", 0, 0, 1, 1, 0, 5'b00000, 0);

    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
